// File: rtl/data_mem.sv
// ---------------------------------------------------------------------------
// data_mem : byte-wide data memory that answers the core datapath.
//
// Purpose
//   The datapath presents a store strobe, store data and a byte address on
//   dmem_in. This block returns load data combinationally on dmem_out.
//   After reset, a fill sequencer writes zero to every location, one location
//   per cycle. Stores are accepted only once ready is high.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset, synchronous release
//   dmem_in   in   struct   .en store strobe, .in store data, .addr byte address
//   dmem_out  out  DATA_W   load data for dmem_in.addr (zero while filling)
//   ready     out  1        fill sequence complete; stores are accepted
//   clr_addr  out  ADDR_W   current fill pointer (debug / observation)
// ---------------------------------------------------------------------------
package data_mem_pkg;
   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 8;

   typedef struct packed {
      logic                   en;
      logic [DMEM_DATA_W-1:0] in;
      logic [DMEM_ADDR_W-1:0] addr;
   } dmem_in_t;
endpackage

module data_mem
   import data_mem_pkg::*;
#(
   parameter int ADDR_W         = DMEM_ADDR_W,
   parameter int DATA_W         = DMEM_DATA_W,
   parameter int DEPTH          = 256,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  dmem_in_t          dmem_in,
   output logic [DATA_W-1:0] dmem_out,
   output logic              ready,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [0:0]        ST_INIT   = 1'b0;
   localparam logic [0:0]        ST_READY  = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   // Without the clear sequence the block comes out of reset already usable.
   localparam logic [0:0] RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
   localparam logic       RST_READY = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [0:0]        state_r;
   logic [0:0]        state_nxt_s;
   logic              ready_r;
   logic              ready_nxt_s;
   logic [ADDR_W-1:0] clr_addr_r;
   logic [ADDR_W-1:0] clr_addr_nxt_s;
   logic [ADDR_W-1:0] addr_s;
   logic              in_range_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [DATA_W-1:0] wr_data_s;

   assign addr_s     = dmem_in.addr;
   // Unsigned compare with one extra bit so DEPTH == 2**ADDR_W still works.
   assign in_range_s = ({1'b0, addr_s} < DEPTH_C);
   assign ready      = ready_r;
   assign clr_addr   = clr_addr_r;

   // Next-state logic of the fill sequencer: INIT walks clr_addr up, READY is terminal.
   always_comb begin
      state_nxt_s    = state_r;
      ready_nxt_s    = ready_r;
      clr_addr_nxt_s = clr_addr_r;
      case (state_r)
         ST_INIT: begin
            if (clr_addr_r == LAST_ADDR) begin
               // Last location is cleared on this edge; pointer parks at DEPTH-1.
               state_nxt_s = ST_READY;
               ready_nxt_s = 1'b1;
            end else begin
               clr_addr_nxt_s = clr_addr_r + ADDR_ONE;
            end
         end
         ST_READY: begin
            ready_nxt_s = 1'b1;
         end
         default: begin
            state_nxt_s    = ST_INIT;
            ready_nxt_s    = 1'b0;
            clr_addr_nxt_s = ADDR_ZERO;
         end
      endcase
   end

   // Sequencer state, ready flag and fill pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= RST_STATE;
         ready_r    <= RST_READY;
         clr_addr_r <= ADDR_ZERO;
      end else begin
         state_r    <= state_nxt_s;
         ready_r    <= ready_nxt_s;
         clr_addr_r <= clr_addr_nxt_s;
      end
   end

   // Write-port select: the fill sequencer owns the port during INIT.
   // Datapath stores go through only in READY with an in-range address.
   // Nothing is written while reset is held, so a store racing reset is lost.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = addr_s;
      wr_data_s = dmem_in.in;
      if (!rst_n) begin
         wr_en_s = 1'b0;
      end else if (state_r == ST_INIT) begin
         wr_en_s   = 1'b1;
         wr_addr_s = clr_addr_r;
         wr_data_s = DATA_ZERO;
      end else if (dmem_in.en && in_range_s) begin
         wr_en_s = 1'b1;
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Storage array; no reset, contents are established by the fill sequence.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_addr_s] <= wr_data_s;
      end
   end

   // Zero-latency load path: old data is visible until the writing edge.
   always_comb begin
      if ((state_r == ST_READY) && in_range_s) begin
         dmem_out = mem_r[addr_s];
      end else begin
         dmem_out = DATA_ZERO;
      end
   end

endmodule
